// File: rtl/bullet_controller.sv
// bullet_controller: owns the ship's bullet pool.
// Spawns a bullet at the ship's nose on a fire-button edge. Each movement tick
// starts a one-slot-per-cycle sweep that moves live bullets up and retires any
// bullet that would cross the top edge. Slot layout on o_bullets:
// [31] active, [30:23] zero, [22:11] x, [10:0] y.
module bullet_controller #(
  parameter int NUM_SLOTS = 24,
  parameter int SIZE      = 64,
  parameter int SPEED     = 4,
  parameter int COOLDOWN  = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      i_tick,
  input  logic                      i_fire_btn,
  input  logic [11:0]               i_ship_col,
  input  logic [10:0]               i_ship_row,
  output logic [NUM_SLOTS*32-1:0]   o_bullets,
  output logic [4:0]                o_active_count,
  output logic                      o_fire_ack,
  output logic                      o_fire_drop,
  output logic                      o_busy
);

  localparam int IDX_W = $clog2(NUM_SLOTS);
  localparam int CD_W  = $clog2(COOLDOWN + 1);
  localparam int SEL_W = IDX_W + 5;

  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_SLOTS - 1);
  localparam logic [11:0]      SPAWN_OFS  = 12'(SIZE / 2);
  localparam logic [10:0]      STEP_Y     = 11'(SPEED);
  localparam logic [CD_W-1:0]  CD_RELOAD  = CD_W'(COOLDOWN);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SCAN = 1'b1
  } state_t;

  // Registered state and outputs
  state_t                    r_state;
  logic [NUM_SLOTS*32-1:0]   r_bullets;
  logic [4:0]                r_active_count;
  logic                      r_fire_ack;
  logic                      r_fire_drop;
  logic                      r_busy;
  logic [IDX_W-1:0]          r_idx;
  logic [CD_W-1:0]           r_cooldown;
  logic                      r_pending;
  logic                      r_fire_prev;

  // Combinational helpers
  logic                      w_fire_edge;
  logic                      w_fire_req;
  logic                      w_free_found;
  logic [IDX_W-1:0]          w_free_idx;
  logic [SEL_W-1:0]          w_scan_sel;
  logic [SEL_W-1:0]          w_spawn_sel;
  logic                      w_cur_active;
  logic [10:0]               w_cur_y;
  logic [11:0]               w_spawn_x;
  logic                      w_can_spawn;

  // A request is a fresh rising edge of the button or one queued earlier.
  assign w_fire_edge  = i_fire_btn & ~r_fire_prev;
  assign w_fire_req   = w_fire_edge | r_pending;

  // Bit offsets of the slot under the sweep and of the slot a spawn would fill.
  assign w_scan_sel   = {r_idx, 5'b00000};
  assign w_spawn_sel  = {w_free_idx, 5'b00000};
  assign w_cur_active = r_bullets[w_scan_sel + SEL_W'(31)];
  assign w_cur_y      = r_bullets[w_scan_sel +: 11];

  // Nose of the ship; wraps naturally in 12 bits.
  assign w_spawn_x    = i_ship_col + SPAWN_OFS;
  assign w_can_spawn  = (r_cooldown == {CD_W{1'b0}}) & w_free_found;

  // Priority encoder: lowest-numbered inactive slot wins.
  always_comb begin
    w_free_found = 1'b0;
    w_free_idx   = {IDX_W{1'b0}};
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      w_free_found = w_free_found | ~r_bullets[32*i + 31];
      w_free_idx   = r_bullets[32*i + 31] ? w_free_idx : IDX_W'(i);
    end
  end

  // Pool FSM: spawn in IDLE, sweep one slot per cycle in SCAN.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_bullets      <= {(NUM_SLOTS*32){1'b0}};
      r_active_count <= 5'd0;
      r_fire_ack     <= 1'b0;
      r_fire_drop    <= 1'b0;
      r_busy         <= 1'b0;
      r_idx          <= {IDX_W{1'b0}};
      r_cooldown     <= {CD_W{1'b0}};
      r_pending      <= 1'b0;
      r_fire_prev    <= 1'b0;
    end else begin
      r_fire_prev <= i_fire_btn;
      r_fire_ack  <= 1'b0;
      r_fire_drop <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (i_tick) begin
            // Tick wins over fire; a same-cycle edge is queued for later.
            r_state <= S_SCAN;
            r_idx   <= {IDX_W{1'b0}};
            r_busy  <= 1'b1;
            if (r_cooldown != {CD_W{1'b0}}) begin
              r_cooldown <= r_cooldown - CD_W'(1);
            end
            if (w_fire_edge) begin
              r_pending <= 1'b1;
            end
          end else if (w_fire_req) begin
            r_pending <= 1'b0;
            if (w_can_spawn) begin
              r_bullets[w_spawn_sel +: 32] <= {1'b1, 8'h00, w_spawn_x, i_ship_row};
              r_active_count               <= r_active_count + 5'd1;
              r_cooldown                   <= CD_RELOAD;
              r_fire_ack                   <= 1'b1;
            end else begin
              r_fire_drop <= 1'b1;
            end
          end
        end

        S_SCAN: begin
          // Only one request can be queued; extra edges are absorbed here.
          if (w_fire_edge) begin
            r_pending <= 1'b1;
          end
          if (w_cur_active) begin
            if (w_cur_y < STEP_Y) begin
              r_bullets[w_scan_sel +: 32] <= 32'h0000_0000;
              r_active_count              <= r_active_count - 5'd1;
            end else begin
              r_bullets[w_scan_sel +: 11] <= w_cur_y - STEP_Y;
            end
          end
          if (r_idx == LAST_IDX) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_bullets      = r_bullets;
  assign o_active_count = r_active_count;
  assign o_fire_ack     = r_fire_ack;
  assign o_fire_drop    = r_fire_drop;
  assign o_busy         = r_busy;

endmodule

// File: tb/tb_bullet_controller.sv
// Directed bench for bullet_controller: a short vector table for the spawn
// and edge-detect behaviour, then hand sequences for scans, cooldown, a full
// pool, a request queued during a scan and a reset that aborts a scan.
module tb_bullet_controller;

  logic         clock = 1'b0;
  logic         reset;
  logic         tick;
  logic         fire;
  logic [11:0]  col;
  logic [10:0]  row;
  logic [767:0] bullets;
  logic [4:0]   active_count;
  logic         fire_ack;
  logic         fire_drop;
  logic         busy;

  int n_pass  = 0;
  int n_total = 0;

  bullet_controller dut (
    .clock          (clock),
    .reset          (reset),
    .i_tick         (tick),
    .i_fire_btn     (fire),
    .i_ship_col     (col),
    .i_ship_row     (row),
    .o_bullets      (bullets),
    .o_active_count (active_count),
    .o_fire_ack     (fire_ack),
    .o_fire_drop    (fire_drop),
    .o_busy         (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        tick;
    logic        fire;
    logic [11:0] col;
    logic [10:0] row;
    logic [31:0] s0;
    logic [31:0] s1;
    logic [4:0]  cnt;
    logic        ack;
    logic        drop;
    logic        busy;
  } vec_t;

  vec_t vecs[6];

  function automatic logic [31:0] mk(input logic [11:0] x, input logic [10:0] y);
    return {1'b1, 8'h00, x, y};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick  = 1'b0;
    fire  = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  // Pulse tick, then wait (bounded) for the sweep to finish; it must last 24 cycles.
  task automatic do_tick();
    int n;
    tick = 1'b1;
    step();
    tick = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      step();
    end
    check("scan_len", 32'(n), 32'd24);
  endtask

  initial begin
    int acks;
    col = 12'd100;
    row = 11'd500;
    do_reset();

    // Reset state
    check("rst_bullets_lo", bullets[31:0], 32'h0);
    check("rst_bullets_hi_zero", {31'h0, (bullets == 768'h0)}, 32'h1);
    check("rst_cnt", 32'(active_count), 32'd0);
    check("rst_flags", {29'h0, fire_ack, fire_drop, busy}, 32'h0);

    // ---- Table: spawn, held button, cooldown drop ----
    vecs[0] = '{1'b0, 1'b0, 12'd100, 11'd500, 32'h0,                      32'h0, 5'd0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 12'd100, 11'd500, mk(12'd132, 11'd500),       32'h0, 5'd1, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 12'd100, 11'd500, mk(12'd132, 11'd500),       32'h0, 5'd1, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 12'd100, 11'd500, mk(12'd132, 11'd500),       32'h0, 5'd1, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 12'd700, 11'd200, mk(12'd132, 11'd500),       32'h0, 5'd1, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 12'd100, 11'd500, mk(12'd132, 11'd500),       32'h0, 5'd1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      tick = vecs[i].tick;
      fire = vecs[i].fire;
      col  = vecs[i].col;
      row  = vecs[i].row;
      step();
      check($sformatf("vec%0d_slot0", i), bullets[31:0],  vecs[i].s0);
      check($sformatf("vec%0d_slot1", i), bullets[63:32], vecs[i].s1);
      check($sformatf("vec%0d_cnt", i),   32'(active_count), 32'(vecs[i].cnt));
      check($sformatf("vec%0d_flags", i), {29'h0, fire_ack, fire_drop, busy},
            {29'h0, vecs[i].ack, vecs[i].drop, vecs[i].busy});
    end

    // ---- One scan moves slot0 up by 4, others stay empty ----
    do_tick();
    check("scan_slot0", bullets[31:0], mk(12'd132, 11'd496));
    check("scan_others_zero", {31'h0, (bullets[767:32] == 736'h0)}, 32'h1);

    // ---- Cooldown: 7 left -> drop; after 7 ticks (1 left) drop; after 8 spawn ----
    fire = 1'b1; step();
    check("cd7_drop", {30'h0, fire_ack, fire_drop}, 32'h1);
    fire = 1'b0; step();
    check("drop_one_cycle", {31'h0, fire_drop}, 32'h0);
    for (int t = 0; t < 6; t++) do_tick();
    fire = 1'b1; step();
    check("cd1_drop", {30'h0, fire_ack, fire_drop}, 32'h1);
    fire = 1'b0; step();
    do_tick();
    col = 12'd4090; row = 11'd300;
    fire = 1'b1; step();
    check("cd0_ack", {30'h0, fire_ack, fire_drop}, 32'h2);
    check("slot1_wrap_x", bullets[63:32], mk(12'd26, 11'd300));
    check("slot0_after8", bullets[31:0], mk(12'd132, 11'd468));
    check("cnt2", 32'(active_count), 32'd2);
    fire = 1'b0; step();

    // ---- Retire: y=4 moves to 0 and stays; y=0 then retires ----
    do_reset();
    col = 12'd100; row = 11'd4;
    fire = 1'b1; step(); fire = 1'b0; step();
    do_tick();
    check("y4_to_0", bullets[31:0], mk(12'd132, 11'd0));
    check("y4_cnt", 32'(active_count), 32'd1);
    do_tick();
    check("retired_slot", bullets[31:0], 32'h0);
    check("retired_cnt", 32'(active_count), 32'd0);

    // ---- Fill all 24 slots, then a fire edge is dropped ----
    do_reset();
    col = 12'd100; row = 11'd1000;
    for (int k = 0; k < 24; k++) begin
      if (k > 0) begin
        for (int t = 0; t < 8; t++) do_tick();
      end
      fire = 1'b1; step();
      check($sformatf("fill%0d_ack", k), {31'h0, fire_ack}, 32'h1);
      check($sformatf("fill%0d_cnt", k), 32'(active_count), 32'(k + 1));
      fire = 1'b0; step();
    end
    for (int t = 0; t < 8; t++) do_tick();
    fire = 1'b1; col = 12'd10; row = 11'd10; step();
    check("full_drop", {30'h0, fire_ack, fire_drop}, 32'h1);
    check("full_cnt", 32'(active_count), 32'd24);
    fire = 1'b0; step();
    // Slot k spawned 8*(23-k) ticks before the last spawn, plus 8 ticks after it.
    for (int k = 0; k < 24; k++) begin
      check($sformatf("full_slot%0d", k), bullets[32*k +: 32],
            mk(12'd132, 11'(1000 - 4 * (8 * (23 - k) + 8))));
    end

    // ---- Fire edge queued during a scan, served right after ----
    do_reset();
    col = 12'd100; row = 11'd500;
    tick = 1'b1; step(); tick = 1'b0;
    for (int c = 0; c < 4; c++) step();
    fire = 1'b1; step(); fire = 1'b0;
    acks = 0;
    for (int c = 0; c < 40 && busy === 1'b1; c++) begin
      if (fire_ack === 1'b1) acks++;
      step();
    end
    check("no_ack_in_scan", 32'(acks), 32'd0);
    check("busy_fell", {31'h0, busy}, 32'h0);
    check("no_spawn_in_scan", bullets[31:0], 32'h0);
    step();
    check("pending_ack", {30'h0, fire_ack, fire_drop}, 32'h2);
    check("pending_slot0", bullets[31:0], mk(12'd132, 11'd500));
    check("pending_cnt", 32'(active_count), 32'd1);

    // ---- Reset mid-scan clears everything at once ----
    tick = 1'b1; step(); tick = 1'b0;
    step(); step();
    reset = 1'b1; step();
    check("midrst_bullets", {31'h0, (bullets == 768'h0)}, 32'h1);
    check("midrst_cnt", 32'(active_count), 32'd0);
    check("midrst_flags", {29'h0, fire_ack, fire_drop, busy}, 32'h0);
    reset = 1'b0; step();
    check("post_rst_idle", {31'h0, busy}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
